run_controller: RTL and testbench
=================================

# run_controller

Execution-control stage directly upstream of the multicycle processor. Turns a raw push-button and a run switch into a clean, one-cycle-per-advance processor enable `cpu_en`, gating the datapath's register enables and FSM from a free-running board clock. Supports single-step, free-run at a divided rate, PC breakpoint and external halt. Also keeps a saturating count of executed processor cycles for the LED display.

## Interface

- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a button level change; legal range 1..65535.
- `RUN_DIV`, default 4: in RUN, one `cpu_en` pulse every `RUN_DIV` clocks; legal range 1..255.

- `clock`  in  1  board clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `step_btn`  in  1  raw push-button, asynchronous to `clock`, 1 = pressed.
- `run_sw`  in  1  1 = free-run requested; treated as quasi-static; double-synchronized.
- `halt_req`  in  1  synchronous halt request from processor control, for example a STOP decode.
- `pc`  in  8  current processor PC.
- `bp_addr`  in  8  breakpoint address.
- `bp_en`  in  1  breakpoint enable.
- `cpu_en`  out  1  processor advance enable; one-cycle pulses only.
- `state`  out  2  current state: IDLE=00, STEP=01, RUN=10, HALT=11.
- `halted`  out  1  1 while in HALT.
- `cycle_count`  out  16  number of `cpu_en` pulses since reset; saturates at 16'hFFFF.

## Operation

- **Input synchronization:** `step_btn` and `run_sw` each pass through a two-flop synchronizer.
- **Debounce:**
  - Counter increments while the synchronized `step_btn` differs from the filtered level. It clears whenever they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the filtered level toggles and the counter clears.
  - A 0→1 edge of the filtered level raises `step_req` for exactly one cycle. The filtered 1→0 edge produces nothing.
- **Per-state behaviour:**
  - **IDLE:**
    - `cpu_en`=0.
    - Synchronized `run_sw`=1 → RUN; this has priority over `step_req`, which is then dropped.
    - Otherwise `step_req` → STEP.
  - **STEP:**
    - `cpu_en`=1 for this single cycle, then → IDLE.
    - Breakpoints are ignored.
  - **RUN:**
    - Divider counts 0..`RUN_DIV`-1 and wraps; it is cleared on entry.
    - When the divider equals `RUN_DIV`-1, this is a pulse slot:
      - If `bp_en`, `pc`==`bp_addr` and `bp_skip`=0: suppress the pulse and → HALT.
      - Otherwise `cpu_en`=1 and `bp_skip` clears.
    - Synchronized `run_sw`=0 → IDLE, divider clears, no pulse that cycle.
  - **HALT:**
    - `cpu_en`=0, `halted`=1.
    - `step_req` while synchronized `run_sw`=0 → IDLE, sets `bp_skip`=1, no pulse.
    - Any other `step_req` is dropped.
- **`bp_skip`:** ensures the first RUN pulse after leaving HALT executes the breakpointed instruction instead of re-halting.
- **`halt_req`:**
  - Sampled in any state other than HALT; it has priority over every other transition.
  - → HALT, and no `cpu_en` that cycle. `cpu_en` is qualified combinationally by `!halt_req`.
- **`cycle_count`:** +1 on every cycle with `cpu_en`=1; holds at 16'hFFFF.
- **Reset values:**
  - `state`=IDLE, `cpu_en`=0, `halted`=0, `cycle_count`=0.
  - Filtered level 0, both counters 0, `bp_skip`=0, synchronizers 0.
  - Reset mid-pulse or mid-debounce aborts immediately; no pulse follows deassertion.

## Timing

- **Step latency:**
  - Raw press first sampled at edge e0.
  - Filtered level rises at edge e0+1+`DEBOUNCE_CYCLES`.
  - `step_req` is high in the following cycle.
  - STEP is entered at edge e0+`DEBOUNCE_CYCLES`+3; `cpu_en` is high for the cycle after that edge.
- **Pulse width:** `cpu_en` is always exactly one clock wide. Two pulses are never adjacent unless `RUN_DIV`=1 in RUN.
- **RUN rate:** first pulse is `RUN_DIV` clocks after RUN entry; thereafter the period is exactly `RUN_DIV`.
- **Breakpoint timing:** `pc` is compared combinationally in the pulse-slot cycle. Since `pc` only changes on `cpu_en`, it is stable at compare.
- **Glitch filtering:** a glitch shorter than `DEBOUNCE_CYCLES` synchronized samples produces no `step_req`.

## Structure

- **Shared package `run_ctrl_pkg`:**
  - State encodings: IDLE/STEP/RUN/HALT 2'b00..2'b11.
  - Width constant `CYCLE_CNT_W`=16.
- **Sub-module `debouncer`:**
  - Contents: synchronizer, stable counter, filtered level, rising-edge pulse.
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clock`, `reset`, `raw`, `level`, `rise`.
- **Top level** holds the `run_sw` synchronizer, FSM, divider, `bp_skip` and `cycle_count`.

## Test plan

- **Single step:** `DEBOUNCE_CYCLES`=4; press held 10 clocks → exactly one `cpu_en` pulse, 7 edges after first sample; `cycle_count`=1; `state` returns to 00.
- **Bounce rejection:** press toggling every 2 clocks for 20 clocks, then released → no `cpu_en`; `cycle_count`=0.
- **Free run:** `run_sw`=1, `RUN_DIV`=4, 40 clocks → pulses spaced exactly 4 clocks; `run_sw`=0 → no further pulses; `state`=00.
- **Breakpoint and resume:**
  - `bp_en`=1, `bp_addr`=8'h05; bench `pc` increments on each `cpu_en`, starting from 0.
  - Expect HALT with `pc`=5, `halted`=1, `cycle_count`=5.
  - Then `run_sw`=0, step, `run_sw`=1 → next pulse occurs at `pc`=5 and run continues.
- **Halt priority:** `halt_req` asserted in a RUN pulse-slot cycle → `cpu_en`=0 that cycle, `state`=11 next; `step_req` with `run_sw`=1 in HALT stays halted.
- **Reset and saturation:**
  - Async reset mid-RUN → all outputs at reset values before the next edge.
  - Preload via 65540 pulses with `RUN_DIV`=1 → `cycle_count` holds 16'hFFFF.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// run_controller shared definitions.
// State encodings and counter width.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    STEP = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } run_state_t;

  localparam int CYCLE_CNT_W = 16;

endpackage

// File: rtl/debouncer.sv
// Push-button conditioner: two-flop sync, stability
// filter and one-cycle pulse on the filtered rising edge.
module debouncer
  import run_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync_a;
  logic        sync_b;
  logic        level_q;
  logic [15:0] cnt;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after it has been stable long enough.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_b == level) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Registered 0->1 detect of the filtered level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_q <= level;
      rise    <= level & ~level_q;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Processor execution control: single-step, divided
// free-run, PC breakpoint, external halt, cycle counter.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RUN_DIV         = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   step_btn,
  input  logic                   run_sw,
  input  logic                   halt_req,
  input  logic [7:0]             pc,
  input  logic [7:0]             bp_addr,
  input  logic                   bp_en,
  output logic                   cpu_en,
  output logic [1:0]             state,
  output logic                   halted,
  output logic [CYCLE_CNT_W-1:0] cycle_count
);

  localparam logic [7:0] DIV_MAX = 8'(RUN_DIV - 1);

  run_state_t cur;
  run_state_t nxt;

  logic       run_a;
  logic       run_s;
  logic       step_req;
  logic       btn_level_unused;
  logic [7:0] div;
  logic       slot;
  logic       bp_hit;
  logic       bp_skip;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clock(clock),
    .reset(reset),
    .raw  (step_btn),
    .level(btn_level_unused),
    .rise (step_req)
  );

  assign state  = cur;
  assign slot   = (div == DIV_MAX);
  assign bp_hit = bp_en && (pc == bp_addr) && !bp_skip;

  // Double-synchronize the run switch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_a <= 1'b0;
      run_s <= 1'b0;
    end else begin
      run_a <= run_sw;
      run_s <= run_a;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur <= IDLE;
    else       cur <= nxt;
  end

  // Next state; an external halt overrides everything.
  always_comb begin
    nxt = cur;
    if (cur != HALT && halt_req) begin
      nxt = HALT;
    end else begin
      unique case (cur)
        IDLE: begin
          if (run_s)         nxt = RUN;
          else if (step_req) nxt = STEP;
        end
        STEP: nxt = IDLE;
        RUN: begin
          if (!run_s)             nxt = IDLE;
          else if (slot && bp_hit) nxt = HALT;
        end
        HALT: begin
          if (step_req && !run_s) nxt = IDLE;
        end
      endcase
    end
  end

  // Advance pulse and halt indicator.
  always_comb begin
    cpu_en = 1'b0;
    halted = 1'b0;
    unique case (cur)
      IDLE: ;
      STEP: cpu_en = !halt_req;
      RUN:  cpu_en = !halt_req && run_s && slot && !bp_hit;
      HALT: halted = 1'b1;
    endcase
  end

  // Rate divider, restarts on every RUN entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         div <= '0;
    else if (cur == RUN && nxt == RUN) div <= slot ? 8'd0 : div + 8'd1;
    else                               div <= '0;
  end

  // Lets the breakpointed instruction execute once on resume.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          bp_skip <= 1'b0;
    else if (cur == HALT && nxt == IDLE) bp_skip <= 1'b1;
    else if (cur == RUN && cpu_en)       bp_skip <= 1'b0;
  end

  // Saturating count of advance pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cycle_count <= '0;
    else if (cpu_en && cycle_count != '1)
      cycle_count <= cycle_count + 1'b1;
  end

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: step, bounce, run,
// breakpoint/resume, halt priority, reset, saturation.
module tb_run_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        step_btn;
  logic        run_sw;
  logic        halt_req;
  logic [7:0]  pc;
  logic [7:0]  bp_addr;
  logic        bp_en;
  logic        cpu_en;
  logic [1:0]  state;
  logic        halted;
  logic [15:0] cycle_count;

  logic        reset_s;
  logic        run_sw_s;
  logic        zero_s = 1'b0;
  logic [7:0]  zero8_s = 8'd0;
  logic        cpu_en_s;
  logic [1:0]  state_s;
  logic        halted_s;
  logic [15:0] cc_s;

  logic        pc_rst;
  logic        en_seen = 1'b0;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  run_controller #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .step_btn   (step_btn),
    .run_sw     (run_sw),
    .halt_req   (halt_req),
    .pc         (pc),
    .bp_addr    (bp_addr),
    .bp_en      (bp_en),
    .cpu_en     (cpu_en),
    .state      (state),
    .halted     (halted),
    .cycle_count(cycle_count)
  );

  run_controller #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (1)
  ) dut_sat (
    .clock      (clock),
    .reset      (reset_s),
    .step_btn   (zero_s),
    .run_sw     (run_sw_s),
    .halt_req   (zero_s),
    .pc         (zero8_s),
    .bp_addr    (zero8_s),
    .bp_en      (zero_s),
    .cpu_en     (cpu_en_s),
    .state      (state_s),
    .halted     (halted_s),
    .cycle_count(cc_s)
  );

  // Processor model: pc advances on each accepted pulse.
  always @(negedge clock) en_seen = cpu_en;
  always @(posedge clock) begin
    if (pc_rst)       pc <= 8'd0;
    else if (en_seen) pc <= pc + 8'd1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    pc_rst   = 1'b1;
    step_btn = 1'b0;
    run_sw   = 1'b0;
    halt_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b0;
    pc_rst = 1'b0;
  endtask

  task automatic watch(input int n, output int cnt,
                       output int first, output int bad);
    int last;
    cnt   = 0;
    first = -1;
    bad   = 0;
    last  = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (cpu_en) begin
        if (cnt == 0)          first = k;
        else if (k - last != 4) bad++;
        last = k;
        cnt++;
      end
    end
  endtask

  // Press held for 10 clocks, pulses counted over n clocks.
  task automatic press(input int n, output int np,
                       output int first, output int st);
    np    = 0;
    first = -1;
    st    = -1;
    @(posedge clock);
    #1 step_btn = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      if (k == 10) step_btn = 1'b0;
      @(negedge clock);
      if (cpu_en) begin
        if (np == 0) begin
          first = k;
          st    = int'(state);
        end
        np++;
      end
    end
  endtask

  initial begin
    int np, first, bad, st, w;

    reset    = 1'b1;
    reset_s  = 1'b1;
    run_sw_s = 1'b0;
    pc_rst   = 1'b1;
    step_btn = 1'b0;
    run_sw   = 1'b0;
    halt_req = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = 8'd0;

    #1;
    chk("rst_state", state, 0);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_count", cycle_count, 0);

    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b0;
    pc_rst = 1'b0;

    // Bounce: 2 high, 2 low for 20 clocks, then released.
    np = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1 step_btn = (k < 20) && (((k / 2) % 2) == 0);
      @(negedge clock);
      if (cpu_en) np++;
    end
    chk("bounce_pulses", np, 0);
    chk("bounce_count", cycle_count, 0);

    // Single step.
    press(30, np, first, st);
    chk("step_pulses", np, 1);
    chk("step_latency", first, 7);
    chk("step_state_on_pulse", st, 1);
    chk("step_count", cycle_count, 1);
    chk("step_state_after", state, 0);

    // Free run at RUN_DIV=4.
    @(posedge clock);
    #1 run_sw = 1'b1;
    watch(40, np, first, bad);
    chk("run_pulses", np, 9);
    chk("run_first", first, 5);
    chk("run_spacing", bad, 0);
    chk("run_state", state, 2);
    @(posedge clock);
    #1 run_sw = 1'b0;
    watch(25, np, first, bad);
    chk("stop_pulses", np, 1);
    chk("stop_last_slot", first, 0);
    chk("stop_count", cycle_count, 11);
    chk("stop_state", state, 0);

    // Breakpoint at 5 and resume.
    bp_en   = 1'b1;
    bp_addr = 8'h05;
    do_reset();
    @(posedge clock);
    #1 run_sw = 1'b1;
    w = 0;
    while (!halted && w < 100) begin
      @(negedge clock);
      w++;
    end
    chk("bp_halted", halted, 1);
    chk("bp_pc", pc, 5);
    chk("bp_count", cycle_count, 5);
    chk("bp_state", state, 3);

    @(posedge clock);
    #1 run_sw = 1'b0;
    repeat (4) @(posedge clock);
    press(15, np, first, st);
    chk("bp_step_pulses", np, 0);
    chk("bp_step_state", state, 0);
    chk("bp_step_halted", halted, 0);
    chk("bp_step_count", cycle_count, 5);

    @(posedge clock);
    #1 run_sw = 1'b1;
    w = 0;
    while (!cpu_en && w < 30) begin
      @(negedge clock);
      w++;
    end
    chk("resume_pulse", cpu_en, 1);
    chk("resume_pc", pc, 5);
    repeat (8) @(negedge clock);
    chk("resume_cont_pulse", cpu_en, 1);
    chk("resume_cont_pc", pc, 7);
    chk("resume_cont_count", cycle_count, 7);
    chk("resume_cont_state", state, 2);

    // Halt request in the next pulse slot.
    bp_en = 1'b0;
    repeat (4) @(posedge clock);
    #1 halt_req = 1'b1;
    @(negedge clock);
    chk("haltreq_cpu_en", cpu_en, 0);
    @(posedge clock);
    #1 halt_req = 1'b0;
    chk("haltreq_state", state, 3);
    chk("haltreq_halted", halted, 1);
    chk("haltreq_count", cycle_count, 8);
    press(30, np, first, st);
    chk("halt_step_run_pulses", np, 0);
    chk("halt_step_run_state", state, 3);

    // Async reset in the middle of a RUN pulse.
    do_reset();
    @(posedge clock);
    #1 run_sw = 1'b1;
    w = 0;
    while (!cpu_en && w < 30) begin
      @(negedge clock);
      w++;
    end
    chk("pre_reset_pulse", cpu_en, 1);
    #1 reset = 1'b1;
    run_sw = 1'b0;
    #1;
    chk("async_rst_cpu_en", cpu_en, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_halted", halted, 0);
    chk("async_rst_count", cycle_count, 0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    watch(10, np, first, bad);
    chk("post_rst_pulses", np, 0);

    // Saturation with RUN_DIV=1.
    @(posedge clock);
    #1;
    reset_s  = 1'b0;
    run_sw_s = 1'b1;
    repeat (1003) @(posedge clock);
    @(negedge clock);
    chk("sat_count_1000", cc_s, 1000);
    chk("sat_adjacent", cpu_en_s, 1);
    repeat (65537 - 1003) @(posedge clock);
    @(negedge clock);
    chk("sat_count_fffe", cc_s, 16'hFFFE);
    repeat (63) @(posedge clock);
    @(negedge clock);
    chk("sat_hold", cc_s, 16'hFFFF);
    chk("sat_still_running", cpu_en_s, 1);
    chk("sat_state", state_s, 2);
    chk("sat_halted", halted_s, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
